// File: rtl/accurate_adder.sv
// Exact signed adder, WIDTH+1-bit result, structural carry-lookahead datapath.
// Latency: 1 cycle (result registered on c), one new operand pair per cycle.
// Backpressure: none; the block consumes a and b at every rising clk edge.
module accurate_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   c
);

  localparam int NBLK = WIDTH / GROUP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] carry_in;
  logic [NBLK-1:0]  blk_g;
  logic [NBLK-1:0]  blk_p;
  logic [NBLK:0]    blk_cin;
  logic             cout_msb;
  logic [WIDTH:0]   s;

  always_comb begin
    logic ci;
    logic term;
    g        = a & b;
    p        = a ^ b;
    carry_in = '0;
    blk_g    = '0;
    blk_p    = '0;
    blk_cin  = '0;
    ci       = 1'b0;
    term     = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      // In-block carries are flat sum-of-products of g/p and the block carry-in.
      for (int j = 0; j < GROUP; j++) begin
        ci = blk_cin[k];
        for (int m = 0; m < j; m++) ci = ci & p[k*GROUP+m];
        for (int m = 0; m < j; m++) begin
          term = g[k*GROUP+m];
          for (int n = m + 1; n < j; n++) term = term & p[k*GROUP+n];
          ci = ci | term;
        end
        carry_in[k*GROUP+j] = ci;
      end
      blk_p[k] = 1'b1;
      for (int j = 0; j < GROUP; j++) blk_p[k] = blk_p[k] & p[k*GROUP+j];
      for (int j = 0; j < GROUP; j++) begin
        term = g[k*GROUP+j];
        for (int m = j + 1; m < GROUP; m++) term = term & p[k*GROUP+m];
        blk_g[k] = blk_g[k] | term;
      end
      blk_cin[k+1] = blk_g[k] | (blk_p[k] & blk_cin[k]);
    end
    cout_msb = g[WIDTH-1] | (p[WIDTH-1] & carry_in[WIDTH-1]);
    s[WIDTH-1:0] = p ^ carry_in;
    // Sign of the extended sum, not the raw carry-out.
    s[WIDTH] = a[WIDTH-1] ^ b[WIDTH-1] ^ cout_msb;
  end

  always_ff @(posedge clk) begin
    if (rst) c <= '0;
    else     c <= s;
  end

endmodule

// File: tb/tb_accurate_adder.sv
// Scoreboard bench for accurate_adder: directed vectors plus a random run with a mid-run reset.
module tb_accurate_adder;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [32:0] c;

  accurate_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .c  (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [32:0] exp_q[$];
  string       name_q[$];
  int          total  = 0;
  int          passed = 0;
  bit          done   = 1'b0;

  // Drive on the falling edge; the next rising edge consumes the vector.
  task automatic drive(input string nm, input logic r, input logic [31:0] va,
                       input logic [31:0] vb, input logic [32:0] ex);
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  // Monitor: the output of each captured vector is valid just after the rising edge.
  initial begin
    logic [32:0] ex;
    string       nm;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (c === ex) passed++;
        else $display("FAIL %s: c=%h expected %h", nm, c, ex);
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] rexp;
    logic        rr;
    int          waited;
    rst = 1'b1;
    a   = '0;
    b   = '0;

    drive("reset_hold",   1'b1, 32'h12345678, 32'h11111111, 33'h000000000);
    drive("reset_release",1'b0, 32'h12345678, 32'h11111111, 33'h023456789);
    drive("five_plus_7",  1'b0, 32'd5,        32'd7,        33'd12);
    drive("neg1_plus_1",  1'b0, 32'hFFFFFFFF, 32'h00000001, 33'h000000000);
    drive("neg1_neg1",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1FFFFFFFE);
    drive("pos_extreme",  1'b0, 32'h7FFFFFFF, 32'h00000001, 33'h080000000);
    drive("neg_extreme",  1'b0, 32'h80000000, 32'h80000000, 33'h100000000);
    drive("max_plus_max", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 33'h0FFFFFFFE);
    drive("min_plus_max", 1'b0, 32'h80000000, 32'h7FFFFFFF, 33'h1FFFFFFFF);
    drive("block_carry",  1'b0, 32'h0000FFFF, 32'h00000001, 33'h000010000);
    drive("mid_reset",    1'b1, 32'd5,        32'd7,        33'h000000000);
    drive("after_reset",  1'b0, 32'h00000010, 32'hFFFFFFF0, 33'h000000000);
    drive("alt_bits",     1'b0, 32'hAAAAAAAA, 32'h55555555, 33'h1FFFFFFFF);
    drive("zero_zero",    1'b0, 32'h00000000, 32'h00000000, 33'h000000000);

    for (int i = 0; i < 2000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rr   = (i == 1000);
      rexp = rr ? 33'h0 : ($signed({ra[31], ra}) + $signed({rb[31], rb}));
      drive("random", rr, ra, rb, rexp);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    done = 1'b1;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
